alu_arbiter: RTL

Shares the single 8-bit ALU among up to `NUM_REQ` requesters: the CPU control FSM, the address/loop unit, and debug. Arbitration is round-robin. The block latches the winning operation and sequences the ALU `enable` / `input_ready` / `result_ready` handshake. It returns the result and flags on a shared response bus. A timeout resets a hung ALU and reports an error to the requester.

---
 rtl/alu_arbiter_if.sv | 61 ++++++
 rtl/alu_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester-side and ALU-side buses of the ALU arbiter

// Requester bus: requesters are masters, the arbiter is the slave.
interface alu_req_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [5*NUM_REQ-1:0] req_opcode;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_carry;
  logic [NUM_REQ-1:0]   req_borrow;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_result;
  logic [4:0]           rsp_flags;
  logic                 rsp_error;

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_carry, req_borrow,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_carry, req_borrow,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
  );
endinterface

// ALU bus: the arbiter is the master, the shared ALU is the slave.
interface alu_core_if;
  logic [4:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_carry;
  logic       alu_borrow;
  logic       alu_enable;
  logic       alu_input_ready;
  logic       alu_rst;
  logic [7:0] alu_result;
  logic       alu_carry_out;
  logic       alu_borrow_out;
  logic       alu_zero;
  logic       alu_negative;
  logic       alu_overflow;
  logic       alu_result_ready;

  modport master (
    output alu_opcode, alu_a, alu_b, alu_carry, alu_borrow,
    output alu_enable, alu_input_ready, alu_rst,
    input  alu_result, alu_carry_out, alu_borrow_out, alu_zero,
    input  alu_negative, alu_overflow, alu_result_ready
  );

  modport slave (
    input  alu_opcode, alu_a, alu_b, alu_carry, alu_borrow,
    input  alu_enable, alu_input_ready, alu_rst,
    output alu_result, alu_carry_out, alu_borrow_out, alu_zero,
    output alu_negative, alu_overflow, alu_result_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one 8-bit ALU with timeout recovery

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_req_if.slave   req_bus,
  alu_core_if.master alu_bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, RECOVER} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   grant_idx;
  logic            grant_found;
  logic [TW-1:0]   timer;
  logic            rec_second;
  logic [7:0]      result_q;
  logic [4:0]      flags_q;

  logic [4:0]      op_q;
  logic [7:0]      a_q, b_q;
  logic            carry_q, borrow_q;

  logic [4:0]      op_sel;
  logic [7:0]      a_sel, b_sel;
  logic            carry_sel, borrow_sel;

  logic [NUM_REQ-1:0] ready_c;
  logic [NUM_REQ-1:0] rsp_valid_c;
  logic [7:0]         rsp_result_c;
  logic [4:0]         rsp_flags_c;
  logic               rsp_error_c;
  logic               enable_c;
  logic               input_ready_c;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    logic [IW:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!grant_found && req_bus.req_valid[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  // Operand mux selecting the winning requester's slice.
  always_comb begin
    op_sel     = '0;
    a_sel      = '0;
    b_sel      = '0;
    carry_sel  = 1'b0;
    borrow_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        op_sel     = req_bus.req_opcode[5*i +: 5];
        a_sel      = req_bus.req_a[8*i +: 8];
        b_sel      = req_bus.req_b[8*i +: 8];
        carry_sel  = req_bus.req_carry[i];
        borrow_sel = req_bus.req_borrow[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    ready_c       = '0;
    rsp_valid_c   = '0;
    rsp_result_c  = '0;
    rsp_flags_c   = '0;
    rsp_error_c   = 1'b0;
    enable_c      = 1'b0;
    input_ready_c = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          ready_c   = onehot(grant_idx);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        enable_c = 1'b1;
        // A result_ready still high here belongs to the previous op.
        if (!alu_bus.alu_result_ready) state_nxt = WAIT;
      end
      WAIT: begin
        enable_c      = 1'b1;
        input_ready_c = 1'b1;
        if (alu_bus.alu_result_ready)  state_nxt = DONE;
        else if (timer == TIMER_LAST)  state_nxt = RECOVER;
      end
      DONE: begin
        rsp_valid_c  = onehot(grant_q);
        rsp_result_c = result_q;
        rsp_flags_c  = flags_q;
        state_nxt    = IDLE;
      end
      RECOVER: begin
        if (rec_second) begin
          rsp_valid_c = onehot(grant_q);
          rsp_error_c = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, grant pointer, timer and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IW'(NUM_REQ - 1);
      grant_q    <= '0;
      timer      <= '0;
      rec_second <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant_q  <= grant_idx;
            op_q     <= op_sel;
            a_q      <= a_sel;
            b_q      <= b_sel;
            carry_q  <= carry_sel;
            borrow_q <= borrow_sel;
          end
        end
        ISSUE: begin
          if (!alu_bus.alu_result_ready) timer <= '0;
        end
        WAIT: begin
          timer      <= timer + 1'b1;
          rec_second <= 1'b0;
          if (alu_bus.alu_result_ready) begin
            result_q <= alu_bus.alu_result;
            flags_q  <= {alu_bus.alu_overflow, alu_bus.alu_negative, alu_bus.alu_zero,
                         alu_bus.alu_borrow_out, alu_bus.alu_carry_out};
          end
        end
        DONE: begin
          last_grant <= grant_q;
        end
        RECOVER: begin
          rec_second <= 1'b1;
          if (rec_second) begin
            rec_second <= 1'b0;
            last_grant <= grant_q;
          end
        end
        default: ;
      endcase
    end
  end

  // req_ready is combinational from req_valid, so hold it low while in reset.
  assign req_bus.req_ready  = rst ? '0 : ready_c;
  assign req_bus.rsp_valid  = rsp_valid_c;
  assign req_bus.rsp_result = rsp_result_c;
  assign req_bus.rsp_flags  = rsp_flags_c;
  assign req_bus.rsp_error  = rsp_error_c;

  assign alu_bus.alu_opcode      = op_q;
  assign alu_bus.alu_a           = a_q;
  assign alu_bus.alu_b           = b_q;
  assign alu_bus.alu_carry       = carry_q;
  assign alu_bus.alu_borrow      = borrow_q;
  assign alu_bus.alu_enable      = enable_c;
  assign alu_bus.alu_input_ready = input_ready_c;
  assign alu_bus.alu_rst         = rst | (state == RECOVER);

endmodule
